signal_switch_arbiter: RTL and testbench
========================================

Name: signal_switch_arbiter

Overview:
- Controller for the 2:1 digital signal switch.
- Shares the switch between two requesters, A and B, and drives the switch's select line.
- Enforces break-before-make switchover: the output is muted for a fixed dead time whenever the select line changes.
- Guarantees a minimum dwell per grant; ties are resolved round-robin.

Parameters:
- DEAD_CYC, 2, mute cycles on every select change; legal range 1..2^CNT_W-1.
- MIN_DWELL, 4, minimum number of cycles a grant is held once issued; legal range 1..2^CNT_W-1.
- MAX_HOLD, 16, forced-release limit in cycles; used only when SWITCH_TIMEOUT_EN is defined; must be >= MIN_DWELL.
- CNT_W, 8, width of the dead-time and dwell counters.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- REQ_A  input  1  requester A wants the switch; level-sensitive.
- REQ_B  input  1  requester B wants the switch; level-sensitive.
- SEL  output  1  select to the switch (0 = IN_A, 1 = IN_B); registered.
- OUT_EN  output  1  switch output enable; 0 = muted; registered.
- GNT_A  output  1  A owns the switch; registered.
- GNT_B  output  1  B owns the switch; registered.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (RST high, async):
  - state = IDLE; SEL = 0; OUT_EN = 0; GNT_A = GNT_B = 0; BUSY = 0.
  - last_owner = B, so A wins the first tie.
  - Both counters = 0.
- States: IDLE, GAP, OWN_A, OWN_B. At most one of GNT_A/GNT_B is high. OUT_EN = 1 only in OWN_x.
- IDLE:
  - REQ_A & REQ_B sampled together: target = the requester that is not last_owner.
  - Only one request: target = that requester.
  - If target's select value == current SEL: go directly to OWN_target on the next edge (no dead time).
  - Otherwise: go to GAP. SEL takes the target value on that same edge; dead counter loads DEAD_CYC-1.
- GAP:
  - OUT_EN = 0, GNT_x = 0.
  - Counter decrements each cycle; at 0, go to OWN_target.
  - GNT_target = 1 and OUT_EN = 1 on that edge; dwell counter clears.
  - Target is latched on GAP entry; request changes during GAP are ignored, and the grant is still issued.
- Latency: request sampled at edge N with an SEL change gives GNT at edge N+1+DEAD_CYC. Without an SEL change, GNT at edge N+1.
- OWN_x:
  - Dwell counter increments, saturating at all-ones.
  - Release is evaluated only once dwell >= MIN_DWELL-1 (grant held >= MIN_DWELL cycles), and only when REQ_x is low.
  - On release, last_owner = x and GNT_x drops on the next edge.
  - If the other requester is high at release: go to GAP toward the other requester.
  - Otherwise: go to IDLE, with OUT_EN = 0 and SEL holding its value.
  - REQ_x dropping before MIN_DWELL does not shorten the grant.
- Simultaneous release by owner and new request from the same owner: not possible, because release is sampled from a low REQ. A re-request on the next cycle competes in IDLE normally.
- Reset mid-GAP or mid-OWN: immediate return to reset values. No completion of the dead time.

Optional Feature:
- Macro: SWITCH_TIMEOUT_EN.
- Defined: in OWN_x, if dwell reaches MAX_HOLD-1 while the other requester is high, ownership is forcibly released even with REQ_x high.
  - Transition to GAP toward the other requester; last_owner = x.
  - The preempted requester, still requesting, is re-granted after the other requester's grant ends.
- Undefined: no timeout logic is built. An owner holds the switch indefinitely while its REQ stays high.

Test Plan:
- Reset with REQ_A = 1 held, then release RST -> one edge later GNT_A = 1, OUT_EN = 1, SEL = 0; no GAP (SEL already 0).
- REQ_B pulse for 1 cycle from IDLE with SEL = 0, DEAD_CYC = 2, MIN_DWELL = 4:
  - SEL = 1 with OUT_EN = 0 for exactly 2 cycles.
  - Then GNT_B = 1 for exactly 4 cycles.
  - Then IDLE, with SEL remaining 1.
- REQ_A and REQ_B raised on the same edge after reset -> A granted first.
  - A drops after 6 cycles -> GAP of 2 cycles, SEL 0 -> 1, then GNT_B.
  - A second tie later -> A wins again (last_owner = B).
- Assert RST for 1 cycle during GAP -> SEL = 0, OUT_EN = 0, both GNTs 0 asynchronously, before the next edge.
- With SWITCH_TIMEOUT_EN, MAX_HOLD = 16: A holds REQ_A high, then B requests -> GNT_A drops after its 16th grant cycle, GAP of 2 cycles, GNT_B. Without the macro -> GNT_A stays high for 100+ cycles.

Source files
------------

// File: rtl/signal_switch_arbiter_if.sv
// Request/grant bundle between the two requesters and the 2:1 signal switch
// arbiter. The master side drives the requests; the arbiter is the slave side.
interface signal_switch_arbiter_if;
    logic REQ_A;
    logic REQ_B;
    logic SEL;
    logic OUT_EN;
    logic GNT_A;
    logic GNT_B;
    logic BUSY;

    modport master (
        output REQ_A, REQ_B,
        input  SEL, OUT_EN, GNT_A, GNT_B, BUSY
    );

    modport slave (
        input  REQ_A, REQ_B,
        output SEL, OUT_EN, GNT_A, GNT_B, BUSY
    );
endinterface

// File: rtl/signal_switch_arbiter.sv
// Break-before-make arbiter for a 2:1 signal switch with minimum dwell and round-robin ties.
// Optional forced release of a held grant is built when SWITCH_TIMEOUT_EN is defined.
module signal_switch_arbiter #(
    parameter int DEAD_CYC  = 2,
    parameter int MIN_DWELL = 4,
    parameter int MAX_HOLD  = 16,
    parameter int CNT_W     = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    signal_switch_arbiter_if.slave      sw
);

    typedef enum logic [1:0] {IDLE, GAP, OWN_A, OWN_B} state_t;

    // Elaboration-time parameter sanity checks.
    if (DEAD_CYC < 1 || DEAD_CYC > (2**CNT_W) - 1) begin : g_bad_dead
        $error("DEAD_CYC out of range");
    end
    if (MIN_DWELL < 1 || MIN_DWELL > (2**CNT_W) - 1) begin : g_bad_dwell
        $error("MIN_DWELL out of range");
    end
    if (MAX_HOLD < MIN_DWELL) begin : g_bad_hold
        $error("MAX_HOLD must be >= MIN_DWELL");
    end

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_MIN = CNT_W'(MIN_DWELL - 1);

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic               out_en_q, out_en_d;
    logic               gnt_a_q, gnt_a_d;
    logic               gnt_b_q, gnt_b_d;
    logic               busy_q, busy_d;
    logic               last_owner_q, last_owner_d;   // 0 = A, 1 = B
    logic               target_q, target_d;           // same encoding as SEL
    logic [CNT_W-1:0]   dead_q, dead_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;

    logic               pick_b;
    logic               own_b;
    logic               own_req;
    logic               oth_req;
    logic               normal_rel;
    logic               force_rel;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        out_en_d     = 1'b0;
        gnt_a_d      = 1'b0;
        gnt_b_d      = 1'b0;
        last_owner_d = last_owner_q;
        target_d     = target_q;
        dead_d       = dead_q;
        dwell_d      = dwell_q;
        pick_b       = sw.REQ_B & (~sw.REQ_A | ~last_owner_q);
        own_b        = (state_q == OWN_B);
        own_req      = own_b ? sw.REQ_B : sw.REQ_A;
        oth_req      = own_b ? sw.REQ_A : sw.REQ_B;
        normal_rel   = (dwell_q >= DWELL_MIN) & ~own_req;
`ifdef SWITCH_TIMEOUT_EN
        force_rel    = (dwell_q >= CNT_W'(MAX_HOLD - 1)) & oth_req;
`else
        force_rel    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (sw.REQ_A | sw.REQ_B) begin
                    target_d = pick_b;
                    if (pick_b == sel_q) begin
                        // Select already points at the winner: no dead time needed.
                        state_d  = pick_b ? OWN_B : OWN_A;
                        gnt_a_d  = ~pick_b;
                        gnt_b_d  = pick_b;
                        out_en_d = 1'b1;
                        dwell_d  = '0;
                    end else begin
                        state_d = GAP;
                        sel_d   = pick_b;
                        dead_d  = DEAD_LOAD;
                    end
                end
            end

            GAP: begin
                if (dead_q == '0) begin
                    state_d  = target_q ? OWN_B : OWN_A;
                    gnt_a_d  = ~target_q;
                    gnt_b_d  = target_q;
                    out_en_d = 1'b1;
                    dwell_d  = '0;
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end

            OWN_A, OWN_B: begin
                dwell_d  = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
                gnt_a_d  = ~own_b;
                gnt_b_d  = own_b;
                out_en_d = 1'b1;
                if (normal_rel | force_rel) begin
                    last_owner_d = own_b;
                    gnt_a_d      = 1'b0;
                    gnt_b_d      = 1'b0;
                    out_en_d     = 1'b0;
                    if (oth_req) begin
                        state_d  = GAP;
                        sel_d    = ~own_b;
                        target_d = ~own_b;
                        dead_d   = DEAD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            out_en_q     <= 1'b0;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            busy_q       <= 1'b0;
            last_owner_q <= 1'b1;
            target_q     <= 1'b0;
            dead_q       <= '0;
            dwell_q      <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            out_en_q     <= out_en_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            busy_q       <= busy_d;
            last_owner_q <= last_owner_d;
            target_q     <= target_d;
            dead_q       <= dead_d;
            dwell_q      <= dwell_d;
        end
    end

    assign sw.SEL    = sel_q;
    assign sw.OUT_EN = out_en_q;
    assign sw.GNT_A  = gnt_a_q;
    assign sw.GNT_B  = gnt_b_q;
    assign sw.BUSY   = busy_q;

endmodule

// File: tb/tb_signal_switch_arbiter.sv
// Directed testbench for signal_switch_arbiter (default parameters).
// Output vector packing: {SEL, OUT_EN, GNT_A, GNT_B, BUSY}.
module tb_signal_switch_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    signal_switch_arbiter_if sw_if ();

    signal_switch_arbiter dut (
        .CLK (CLK),
        .RST (RST),
        .sw  (sw_if.slave)
    );

    always #5 CLK = ~CLK;

    logic [4:0] obs;
    assign obs = {sw_if.SEL, sw_if.OUT_EN, sw_if.GNT_A, sw_if.GNT_B, sw_if.BUSY};

    localparam logic [4:0] I_0 = 5'b00000;  // idle, SEL=0
    localparam logic [4:0] I_1 = 5'b10000;  // idle, SEL=1
    localparam logic [4:0] G_A = 5'b00001;  // gap toward A
    localparam logic [4:0] G_B = 5'b10001;  // gap toward B
    localparam logic [4:0] O_A = 5'b01101;  // A owns
    localparam logic [4:0] O_B = 5'b11011;  // B owns

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        sw_if.REQ_A = 1'b0;
        sw_if.REQ_B = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        sw_if.REQ_A = 1'b1;
        sw_if.REQ_B = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== I_0) begin errors++; $display("FAIL reset_hold obs=%b want=%b", obs, I_0); end
        RST = 1'b0;
        tick();
        checks++;
        if (obs !== O_A) begin errors++; $display("FAIL reset_grant_a obs=%b want=%b", obs, O_A); end
        sw_if.REQ_A = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== O_A) begin errors++; $display("FAIL min_dwell_a[%0d] obs=%b want=%b", i, obs, O_A); end
        end
        tick();
        checks++;
        if (obs !== I_0) begin errors++; $display("FAIL release_a obs=%b want=%b", obs, I_0); end
    endtask

    task automatic test_gap_pulse();
        do_reset();
        sw_if.REQ_B = 1'b1;
        tick();
        sw_if.REQ_B = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs !== G_B) begin errors++; $display("FAIL pulse_gap[%0d] obs=%b want=%b", i, obs, G_B); end
            if (i == 0) tick();
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== O_B) begin errors++; $display("FAIL pulse_own_b[%0d] obs=%b want=%b", i, obs, O_B); end
        end
        tick();
        checks++;
        if (obs !== I_1) begin errors++; $display("FAIL pulse_idle obs=%b want=%b", obs, I_1); end
    endtask

    task automatic test_tie();
        do_reset();
        sw_if.REQ_A = 1'b1;
        sw_if.REQ_B = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (obs !== O_A) begin errors++; $display("FAIL tie_own_a[%0d] obs=%b want=%b", i, obs, O_A); end
        end
        sw_if.REQ_A = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== G_B) begin errors++; $display("FAIL tie_gap_b[%0d] obs=%b want=%b", i, obs, G_B); end
        end
        tick();
        checks++;
        if (obs !== O_B) begin errors++; $display("FAIL tie_grant_b obs=%b want=%b", obs, O_B); end
        sw_if.REQ_B = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tick();
        checks++;
        if (obs !== I_1) begin errors++; $display("FAIL tie_idle obs=%b want=%b", obs, I_1); end
        sw_if.REQ_A = 1'b1;
        sw_if.REQ_B = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== G_A) begin errors++; $display("FAIL tie2_gap_a[%0d] obs=%b want=%b", i, obs, G_A); end
        end
        tick();
        checks++;
        if (obs !== O_A) begin errors++; $display("FAIL tie2_grant_a obs=%b want=%b", obs, O_A); end
        sw_if.REQ_A = 1'b0;
        sw_if.REQ_B = 1'b0;
    endtask

    task automatic test_reset_in_gap();
        do_reset();
        sw_if.REQ_B = 1'b1;
        tick();
        checks++;
        if (obs !== G_B) begin errors++; $display("FAIL rgap_enter obs=%b want=%b", obs, G_B); end
        RST = 1'b1;
        #1;
        checks++;
        if (obs !== I_0) begin errors++; $display("FAIL rgap_async obs=%b want=%b", obs, I_0); end
        sw_if.REQ_B = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        checks++;
        if (obs !== I_0) begin errors++; $display("FAIL rgap_after obs=%b want=%b", obs, I_0); end
    endtask

    task automatic test_hold();
        do_reset();
        sw_if.REQ_A = 1'b1;
        tick();
        checks++;
        if (obs !== O_A) begin errors++; $display("FAIL hold_grant_a obs=%b want=%b", obs, O_A); end
        sw_if.REQ_B = 1'b1;
`ifdef SWITCH_TIMEOUT_EN
        for (int i = 2; i <= 16; i++) begin
            tick();
            checks++;
            if (obs !== O_A) begin errors++; $display("FAIL hold_a_cyc%0d obs=%b want=%b", i, obs, O_A); end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== G_B) begin errors++; $display("FAIL timeout_gap[%0d] obs=%b want=%b", i, obs, G_B); end
        end
        tick();
        checks++;
        if (obs !== O_B) begin errors++; $display("FAIL timeout_grant_b obs=%b want=%b", obs, O_B); end
        sw_if.REQ_B = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== G_A) begin errors++; $display("FAIL regrant_gap[%0d] obs=%b want=%b", i, obs, G_A); end
        end
        tick();
        checks++;
        if (obs !== O_A) begin errors++; $display("FAIL regrant_a obs=%b want=%b", obs, O_A); end
`else
        for (int i = 2; i <= 120; i++) begin
            tick();
            checks++;
            if (obs !== O_A) begin errors++; $display("FAIL hold_a_cyc%0d obs=%b want=%b", i, obs, O_A); end
        end
        sw_if.REQ_A = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== G_B) begin errors++; $display("FAIL handoff_gap[%0d] obs=%b want=%b", i, obs, G_B); end
        end
        tick();
        checks++;
        if (obs !== O_B) begin errors++; $display("FAIL handoff_grant_b obs=%b want=%b", obs, O_B); end
`endif
        sw_if.REQ_A = 1'b0;
        sw_if.REQ_B = 1'b0;
    endtask

    initial begin
        sw_if.REQ_A = 1'b0;
        sw_if.REQ_B = 1'b0;
        test_reset();
        test_gap_pulse();
        test_tie();
        test_reset_in_gap();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
